// File: rtl/pipe_stage_reg.sv
// Elastic pipeline register carrying a control and a data field with a valid/ready handshake, flush and reset.
// Define PIPE_STAGE_SKID_EN to add a two-entry skid buffer so in_ready comes straight from a flop.
module pipe_stage_reg #(
    parameter int CTRL_W = 5,
    parameter int DATA_W = 102
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [1:0]        count_q, count_d;
    logic              inFire, outFire;

`ifdef PIPE_STAGE_SKID_EN
    logic [CTRL_W-1:0] skidCtrl_q, skidCtrl_d;
    logic [DATA_W-1:0] skidData_q, skidData_d;
    logic              inReady_q, inReady_d;

    assign in_ready = inReady_q;
`else
    assign in_ready = !valid_q || out_ready;
`endif

    assign outFire = valid_q && out_ready;
    assign inFire  = in_valid && in_ready;

    // The main register is always the one presented downstream; the skid register only ever feeds it.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
`ifdef PIPE_STAGE_SKID_EN
        skidCtrl_d = skidCtrl_q;
        skidData_d = skidData_q;
`endif
        case (state_q)
            EMPTY: begin
                if (inFire) begin
                    state_d = ONE;
                    ctrl_d  = in_ctrl;
                    data_d  = in_data;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    ctrl_d = in_ctrl;
                    data_d = in_data;
`ifdef PIPE_STAGE_SKID_EN
                end else if (inFire) begin
                    state_d    = TWO;
                    skidCtrl_d = in_ctrl;
                    skidData_d = in_data;
`endif
                end else if (outFire) begin
                    state_d = EMPTY;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            TWO: begin
                if (outFire) begin
                    state_d = ONE;
                    ctrl_d  = skidCtrl_q;
                    data_d  = skidData_q;
                end
            end
`endif
            default: state_d = EMPTY;
        endcase

        // A flushed input never reaches the data register, so out_data keeps the last word shown.
        if (flush) begin
            state_d = EMPTY;
            data_d  = data_q;
        end

        if (state_d == EMPTY) begin
            ctrl_d = '0;
        end

        valid_d = (state_d != EMPTY);
        case (state_d)
            ONE:     count_d = 2'd1;
            TWO:     count_d = 2'd2;
            default: count_d = 2'd0;
        endcase
`ifdef PIPE_STAGE_SKID_EN
        inReady_d = (state_d != TWO);
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= EMPTY;
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            count_q <= 2'd0;
`ifdef PIPE_STAGE_SKID_EN
            skidCtrl_q <= '0;
            skidData_q <= '0;
            inReady_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
`ifdef PIPE_STAGE_SKID_EN
            skidCtrl_q <= skidCtrl_d;
            skidData_q <= skidData_d;
            inReady_q  <= inReady_d;
`endif
        end
    end

    assign out_valid = valid_q;
    assign out_ctrl  = ctrl_q;
    assign out_data  = data_q;
    assign count     = count_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: accepted words queue up in a FIFO model, a monitor pops them as they leave.
// Builds with or without PIPE_STAGE_SKID_EN; occupancy and ready expectations follow the selected mode.
module tb_pipe_stage_reg;

    localparam int CTRL_W = 5;
    localparam int DATA_W = 102;
`ifdef PIPE_STAGE_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic              clk;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        count;

    logic [CTRL_W+DATA_W-1:0] expQ[$];
    logic [DATA_W-1:0]        lastShown;
    logic                     monEn;
    int                       checks;
    int                       errors;

    pipe_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .count     (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at negedge, sample the handshake, then update the FIFO model after the monitor ran.
    task automatic applyStimulus(input logic inV, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d,
                                 input logic outR, input logic fl, input logic rstN, output logic fired);
        @(negedge clk);
        in_valid  = inV;
        in_ctrl   = c;
        in_data   = d;
        out_ready = outR;
        flush     = fl;
        rst       = rstN;
        #1;
        fired = rstN && inV && (in_ready === 1'b1);
        #2;
        if (!rstN) begin
            expQ.delete();
            lastShown = '0;
        end else if (fl) begin
            expQ.delete();
        end else if (fired) begin
            expQ.push_back({c, d});
        end
    endtask

    function automatic logic [DATA_W-1:0] randData();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[DATA_W-1:0];
    endfunction

    // Monitor: compares occupancy, ready and the presented word against the FIFO model every cycle.
    initial begin
        logic [CTRL_W+DATA_W-1:0] exp;
        logic                     expReady;
        forever begin
            @(negedge clk);
            #2;
            if (monEn) begin
                checkOutput("count", count, expQ.size());
                checkOutput("out_valid", out_valid, expQ.size() > 0);
                if (DEPTH == 2) expReady = (expQ.size() < 2);
                else            expReady = (expQ.size() == 0) || out_ready;
                checkOutput("in_ready", in_ready, expReady);
                if (out_valid !== 1'b1) begin
                    checkOutput("bubble_ctrl", out_ctrl, 0);
                    checkOutput("hold_data", out_data, lastShown);
                end else begin
                    lastShown = out_data;
                    if (rst && out_ready && expQ.size() > 0) begin
                        exp = expQ.pop_front();
                        checkOutput("word", {out_ctrl, out_data}, exp);
                    end
                end
            end
        end
    end

    initial begin
        logic              f;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] bubbleData;
        int                guard;
        checks    = 0;
        errors    = 0;
        monEn     = 1'b0;
        lastShown = '0;
        rst       = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset held three cycles with a word offered; nothing may be taken.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 5'd3, 'hABC, 1'b1, 1'b0, 1'b0, f);
        monEn = 1'b1;
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_ctrl", out_ctrl, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_count", count, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, f);
        checkOutput("rst_nothing_taken", out_valid, 0);

        // Streaming 1..8 with downstream always ready.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, CTRL_W'(i), DATA_W'(i), 1'b1, 1'b0, 1'b1, f);
            checkOutput("stream_accept", f, 1);
            if (i > 1) checkOutput("stream_count", count, 1);
        end
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);

        // Backpressure: A, B, C offered while downstream stalls.
        applyStimulus(1'b1, 5'h0A, DATA_W'('hA), 1'b0, 1'b0, 1'b1, f);
        checkOutput("bp_accept_a", f, 1);
        applyStimulus(1'b1, 5'h0B, DATA_W'('hB), 1'b0, 1'b0, 1'b1, f);
        checkOutput("bp_accept_b", f, DEPTH == 2);
        if (!f) begin
            guard = 0;
            do begin
                applyStimulus(1'b1, 5'h0B, DATA_W'('hB), guard > 0, 1'b0, 1'b1, f);
                guard++;
            end while (!f && guard < 8);
            checkOutput("bp_b_eventually", f, 1);
        end else begin
            applyStimulus(1'b1, 5'h0C, DATA_W'('hC), 1'b0, 1'b0, 1'b1, f);
            checkOutput("bp_in_ready_low", in_ready, 0);
            checkOutput("bp_count_two", count, 2);
        end
        guard = 0;
        do begin
            applyStimulus(1'b1, 5'h0C, DATA_W'('hC), 1'b1, 1'b0, 1'b1, f);
            guard++;
        end while (!f && guard < 8);
        checkOutput("bp_c_accepted", f, 1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
        checkOutput("bp_drained", expQ.size(), 0);

        // Flush with entries held and word D offered in the same cycle.
        applyStimulus(1'b1, 5'h01, DATA_W'('h11), 1'b0, 1'b0, 1'b1, f);
        applyStimulus(1'b1, 5'h02, DATA_W'('h22), 1'b0, 1'b0, 1'b1, f);
        applyStimulus(1'b1, 5'h0D, DATA_W'('hDD), 1'b0, 1'b1, 1'b1, f);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
        checkOutput("flush_out_valid", out_valid, 0);
        checkOutput("flush_out_ctrl", out_ctrl, 0);
        checkOutput("flush_count", count, 0);
        checkOutput("flush_in_ready", in_ready, 1);

        // Bubble: a single control word drains and the data field holds.
        bubbleData = randData();
        applyStimulus(1'b1, 5'b10110, bubbleData, 1'b1, 1'b0, 1'b1, f);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
        checkOutput("bubble_valid_ctrl", out_ctrl, 5'b10110);
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
        checkOutput("bubble_dropped_ctrl", out_ctrl, 0);
        checkOutput("bubble_held_data", out_data, bubbleData);

        // Random handshake traffic with occasional flush and reset.
        for (int i = 0; i < 10000; i++) begin
            d = randData();
            applyStimulus($urandom_range(0, 3) != 0, CTRL_W'($urandom), d,
                          $urandom_range(0, 2) != 0, $urandom_range(0, 99) == 0,
                          $urandom_range(0, 999) != 0, f);
        end

        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
            guard++;
        end
        applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b1, f);
        checkOutput("final_drain", expQ.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
